// File: rtl/raiz_bus_master.sv
// -----------------------------------------------------------------------------
// raiz_bus_master
//
// Bus master that drives a memory-mapped square-root peripheral. On an accepted
// start it writes the operand, pulses the peripheral's init register (1 then 0),
// polls the done flag until bit 0 is set, then reads back the remainder and the
// root. A one-cycle valid pulse marks the cycle in which both results are final.
//
// Optional feature (macro RAIZ_POLL_TIMEOUT_EN):
//   Counts done-polls that come back 0. When the POLL_MAX-th check still sees
//   done=0 the command is abandoned: the FSM returns to IDLE, timeout pulses for
//   one cycle, valid stays low and the results keep their previous values.
//   Without the macro the block polls indefinitely and timeout is tied to 0.
//
// Ports:
//   clk          clock, all state changes on rising edge
//   rst          synchronous active-high reset
//   start        command request, sampled only in IDLE
//   operand      value to square-root, latched on start acceptance
//   busy         high in every state except IDLE
//   valid        one-cycle pulse, results final while high
//   result_r     captured remainder
//   result_q     captured root
//   timeout      one-cycle pulse on poll timeout (0 without the macro)
//   cs/rd/wr     peripheral bus strobes
//   addr         peripheral register address
//   bus_dout     write data to the peripheral
//   bus_din      registered read data from the peripheral
//   o_dbg_state  current FSM state, for observation only
//
// Handshake: start is a level request. It is accepted on the rising edge where
// the FSM is in IDLE and start=1; anything presented while busy (including the
// DONE cycle) is dropped, never queued. valid is a single-cycle pulse with no
// back-pressure; the consumer must take result_r/result_q in that cycle or
// later, since they hold until the next capture.
// -----------------------------------------------------------------------------
module raiz_bus_master #(
    parameter logic [4:0] ADDR_OP   = 5'h04,
    parameter logic [4:0] ADDR_INIT = 5'h08,
    parameter logic [4:0] ADDR_R    = 5'h0C,
    parameter logic [4:0] ADDR_Q    = 5'h10,
    parameter logic [4:0] ADDR_DONE = 5'h14,
    parameter int         POLL_MAX  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] operand,
    output logic        busy,
    output logic        valid,
    output logic [15:0] result_r,
    output logic [15:0] result_q,
    output logic        timeout,
    output logic        cs,
    output logic        rd,
    output logic        wr,
    output logic [4:0]  addr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    output logic [3:0]  o_dbg_state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_OP    = 4'd1,
        WR_INIT1 = 4'd2,
        WR_INIT0 = 4'd3,
        POLL_REQ = 4'd4,
        POLL_CHK = 4'd5,
        RD_R_REQ = 4'd6,
        RD_R_CAP = 4'd7,
        RD_Q_REQ = 4'd8,
        RD_Q_CAP = 4'd9,
        DONE     = 4'd10
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_operand;
    logic [15:0] r_result_r;
    logic [15:0] r_result_q;
    logic        w_accept;

    assign w_accept = (r_state == IDLE) && start;

`ifdef RAIZ_POLL_TIMEOUT_EN
    localparam int CNT_W = $clog2(POLL_MAX + 1);

    logic [CNT_W-1:0] r_poll_cnt;
    logic             r_timeout;
    logic             w_poll_last;
    logic             w_tmo_fire;

    // The current check is the POLL_MAX-th one when POLL_MAX-1 zeros came before.
    assign w_poll_last = (r_poll_cnt == CNT_W'(POLL_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_poll_cnt <= '0;
        end else if (w_accept) begin
            r_poll_cnt <= '0;
        end else if ((r_state == POLL_CHK) && !bus_din[0]) begin
            r_poll_cnt <= r_poll_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo_fire;
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_poll_max;

    assign w_unused_poll_max = (POLL_MAX != 0);
    assign timeout           = 1'b0;
`endif

    // State register and datapath captures
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_operand  <= 16'h0000;
            r_result_r <= 16'h0000;
            r_result_q <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_operand <= operand;
            end
            // Peripheral read data is registered: it appears in the cycle after the request.
            if (r_state == RD_R_CAP) begin
                r_result_r <= bus_din;
            end
            if (r_state == RD_Q_CAP) begin
                r_result_q <= bus_din;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
`ifdef RAIZ_POLL_TIMEOUT_EN
        w_tmo_fire = 1'b0;
`endif
        case (r_state)
            IDLE:     if (start) w_next = WR_OP;
            WR_OP:    w_next = WR_INIT1;
            WR_INIT1: w_next = WR_INIT0;
            WR_INIT0: w_next = POLL_REQ;
            POLL_REQ: w_next = POLL_CHK;
            POLL_CHK: begin
                // Only bit 0 carries the done flag; the rest of the word is ignored.
                if (bus_din[0]) begin
                    w_next = RD_R_REQ;
                end else begin
`ifdef RAIZ_POLL_TIMEOUT_EN
                    if (w_poll_last) begin
                        w_next     = IDLE;
                        w_tmo_fire = 1'b1;
                    end else begin
                        w_next = POLL_REQ;
                    end
`else
                    w_next = POLL_REQ;
`endif
                end
            end
            RD_R_REQ: w_next = RD_R_CAP;
            RD_R_CAP: w_next = RD_Q_REQ;
            RD_Q_REQ: w_next = RD_Q_CAP;
            RD_Q_CAP: w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Moore bus decode: strobes, address and write data depend on state only.
    always_comb begin
        cs       = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        addr     = 5'h00;
        bus_dout = 16'h0000;
        case (r_state)
            WR_OP: begin
                cs       = 1'b1;
                wr       = 1'b1;
                addr     = ADDR_OP;
                bus_dout = r_operand;
            end
            WR_INIT1: begin
                cs       = 1'b1;
                wr       = 1'b1;
                addr     = ADDR_INIT;
                bus_dout = 16'h0001;
            end
            WR_INIT0: begin
                cs   = 1'b1;
                wr   = 1'b1;
                addr = ADDR_INIT;
            end
            POLL_REQ: begin
                cs   = 1'b1;
                rd   = 1'b1;
                addr = ADDR_DONE;
            end
            RD_R_REQ: begin
                cs   = 1'b1;
                rd   = 1'b1;
                addr = ADDR_R;
            end
            RD_Q_REQ: begin
                cs   = 1'b1;
                rd   = 1'b1;
                addr = ADDR_Q;
            end
            default: begin
                cs = 1'b0;
            end
        endcase
    end

    assign busy        = (r_state != IDLE);
    assign valid       = (r_state == DONE);
    assign result_r    = r_result_r;
    assign result_q    = r_result_q;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_raiz_bus_master.sv
// Bench for raiz_bus_master: a registered peripheral model answers the bus,
// results expected from each command are queued when the command is issued and
// a negedge monitor pops and compares them whenever valid is seen.
module tb_raiz_bus_master;
  localparam logic [4:0] A_OP   = 5'h04;
  localparam logic [4:0] A_INIT = 5'h08;
  localparam logic [4:0] A_R    = 5'h0C;
  localparam logic [4:0] A_Q    = 5'h10;
  localparam logic [4:0] A_DONE = 5'h14;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] operand;
  logic        busy;
  logic        valid;
  logic [15:0] result_r;
  logic [15:0] result_q;
  logic        timeout;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [4:0]  addr;
  logic [15:0] bus_dout;
  logic [15:0] bus_din;
  logic [3:0]  dbg_state;

  raiz_bus_master #(
    .ADDR_OP(A_OP), .ADDR_INIT(A_INIT), .ADDR_R(A_R), .ADDR_Q(A_Q),
    .ADDR_DONE(A_DONE), .POLL_MAX(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .operand(operand),
    .busy(busy), .valid(valid), .result_r(result_r), .result_q(result_q),
    .timeout(timeout), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .bus_dout(bus_dout), .bus_din(bus_din), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required end before it", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [22:0] trace_q[$];
  int          op_cyc_q[$];
  int          poll_req_cnt = 0;
  int          valid_cnt = 0;
  int          tmo_cnt = 0;
  int          tmo_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [22:0] ev(input logic w, input logic r, input logic [4:0] a,
                                     input logic [15:0] d);
    return {w, r, a, d};
  endfunction

  // ---------------- peripheral model (registered read data) ----------------
  int          poll_count = 0;
  int          done_after = 1;
  logic [15:0] mdl_r = 16'h0;
  logic [15:0] mdl_q = 16'h0;
  bit          garbage = 1'b0;

  initial bus_din = 16'h0;
  always @(posedge clk) begin
    if (cs && wr && addr == A_INIT && bus_dout == 16'h0000) poll_count <= 0;
    if (cs && rd) begin
      if (addr == A_DONE) begin
        poll_count <= poll_count + 1;
        bus_din <= {(garbage ? 15'($urandom_range(1, 32767)) : 15'h0),
                    ((poll_count + 1) >= done_after)};
      end else if (addr == A_R) begin
        bus_din <= mdl_r;
      end else if (addr == A_Q) begin
        bus_din <= mdl_q;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        chk("result_rq", {result_r, result_q}, exp_q.pop_front());
      end
    end
    if (cs) trace_q.push_back({wr, rd, addr, bus_dout});
    if (cs && wr && addr == A_OP) op_cyc_q.push_back(cyc);
    if (cs && rd && addr == A_DONE) poll_req_cnt++;
    if (timeout) begin
      tmo_cnt++;
      tmo_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one start while the DUT is idle; s = cycle count after the accepting edge.
  task automatic issue(input logic [15:0] op, input logic [15:0] r, input logic [15:0] q,
                       input int da, input bit garb, input bit expect_res, output int s);
    operand    = op;
    mdl_r      = r;
    mdl_q      = q;
    done_after = da;
    garbage    = garb;
    if (expect_res) exp_q.push_back({r, q});
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_valid(input int budget, output int vc);
    bit seen;
    seen = 1'b0;
    vc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        vc = cyc;
      end
    end
    chk("valid_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    chk("returned_idle", 32'(idle), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    int vc;
    int vbase;
    bit found;
    logic [22:0] exp_trace[$];

    rst = 1'b1;
    start = 1'b0;
    operand = 16'h0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_cs_rd_wr", {29'd0, cs, rd, wr}, 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_bus_dout", 32'(bus_dout), 32'd0);
    chk("rst_results", {result_r, result_q}, 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // sqrt(144): done after 3 polls, operand changed right after acceptance
    trace_q.delete();
    issue(16'd144, 16'd0, 16'd12, 3, 1'b0, 1'b1, s);
    operand = 16'hDEAD;
    wait_valid(40, vc);
    chk("lat_3polls", 32'(vc - s), 32'd13);
    exp_trace = '{ev(1, 0, A_OP, 16'd144), ev(1, 0, A_INIT, 16'h0001), ev(1, 0, A_INIT, 16'h0000),
                   ev(0, 1, A_DONE, 16'h0), ev(0, 1, A_DONE, 16'h0), ev(0, 1, A_DONE, 16'h0),
                   ev(0, 1, A_R, 16'h0), ev(0, 1, A_Q, 16'h0)};
    chk("trace_len", 32'(trace_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < trace_q.size()) chk($sformatf("trace_%0d", i), 32'(trace_q[i]), 32'(exp_trace[i]));
    end

    // Minimum latency, done on first poll
    @(negedge clk);
    issue(16'd50, 16'd1, 16'd7, 1, 1'b0, 1'b1, s);
    wait_valid(30, vc);
    chk("lat_min", 32'(vc - s), 32'd9);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("valid_pulse_len", 32'(valid), 32'd0);

    // start held high for 20 cycles: two commands, 11 cycles apart
    op_cyc_q.delete();
    vbase = valid_cnt;
    operand = 16'd200;
    mdl_r = 16'd4;
    mdl_q = 16'd14;
    done_after = 1;
    exp_q.push_back({16'd4, 16'd14});
    exp_q.push_back({16'd4, 16'd14});
    start = 1'b1;
    repeat (20) tick();
    start = 1'b0;
    wait_idle(40);
    chk("held_op_writes", 32'(op_cyc_q.size()), 32'd2);
    if (op_cyc_q.size() == 2) chk("held_op_gap", 32'(op_cyc_q[1] - op_cyc_q[0]), 32'd11);
    chk("held_valids", 32'(valid_cnt - vbase), 32'd2);

    // Reset during POLL_REQ
    vbase = valid_cnt;
    issue(16'd99, 16'h1234, 16'h5678, 1000, 1'b0, 1'b0, s);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cs && rd && addr == A_DONE) found = 1'b1;
    end
    chk("reached_poll_req", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_cs_rd", {30'd0, cs, rd}, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_results", {result_r, result_q}, 32'd0);
    repeat (12) @(negedge clk);
    chk("midrst_no_valid", 32'(valid_cnt - vbase), 32'd0);

    // start coincident with reset is dropped
    op_cyc_q.delete();
    rst = 1'b1;
    start = 1'b1;
    operand = 16'd5;
    tick();
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_start_no_op", 32'(op_cyc_q.size()), 32'd0);

    // All-ones results, garbage in upper done bits
    poll_req_cnt = 0;
    issue(16'hFFFF, 16'hFFFF, 16'hFFFF, 3, 1'b1, 1'b1, s);
    wait_valid(40, vc);
    chk("garbage_polls", 32'(poll_req_cnt), 32'd3);
    chk("garbage_lat", 32'(vc - s), 32'd13);
    @(negedge clk);
    garbage = 1'b0;

    // Done never set
    tmo_cnt = 0;
    poll_req_cnt = 0;
    vbase = valid_cnt;
    issue(16'd9, 16'h0, 16'h3, 1000, 1'b0, 1'b0, s);
`ifdef RAIZ_POLL_TIMEOUT_EN
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (timeout) begin
        found = 1'b1;
        chk("tmo_busy", 32'(busy), 32'd0);
      end
    end
    chk("tmo_seen", 32'(found), 32'd1);
    chk("tmo_polls", 32'(poll_req_cnt), 32'd4);
    chk("tmo_cycle", 32'(tmo_cyc - s), 32'd11);
    @(negedge clk);
    chk("tmo_pulse_len", 32'(timeout), 32'd0);
    chk("tmo_results_kept", {result_r, result_q}, 32'hFFFF_FFFF);
    chk("tmo_no_valid", 32'(valid_cnt - vbase), 32'd0);
`else
    repeat (30) @(negedge clk);
    chk("nomacro_no_timeout", 32'(tmo_cnt), 32'd0);
    chk("nomacro_still_busy", 32'(busy), 32'd1);
    chk("nomacro_keeps_polling", 32'(poll_req_cnt >= 10), 32'd1);
    chk("nomacro_results_kept", {result_r, result_q}, 32'hFFFF_FFFF);
    chk("nomacro_no_valid", 32'(valid_cnt - vbase), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/raiz_bus_master.md
RAIZ_BUS_MASTER -- requirements
Module: raiz_bus_master

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ADDR_OP, default 5'h04: operand register address.
REQ-002 The block SHALL have parameter ADDR_INIT, default 5'h08: init register address.
REQ-003 The block SHALL have parameter ADDR_R, default 5'h0C: remainder result address.
REQ-004 The block SHALL have parameter ADDR_Q, default 5'h10: root result address.
REQ-005 The block SHALL have parameter ADDR_DONE, default 5'h14: done flag address, bit 0.
REQ-006 The block SHALL have parameter POLL_MAX, default 1024: done-checks before timeout; used only with RAIZ_POLL_TIMEOUT_EN.

Ports (name, direction, width, meaning):
REQ-007 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-009 The block SHALL have port start, input, 1: command request, sampled only in IDLE.
REQ-010 The block SHALL have port operand, input, 16: value to be square-rooted, latched on start acceptance.
REQ-011 The block SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 The block SHALL have port valid, output, 1: one-cycle pulse; result_r and result_q are final while it is high.
REQ-013 The block SHALL have port result_r, output, 16: captured remainder.
REQ-014 The block SHALL have port result_q, output, 16: captured root.
REQ-015 The block SHALL have port timeout, output, 1: one-cycle pulse on poll timeout; constant 0 when the macro is absent.
REQ-016 The block SHALL have the bus ports cs, rd, wr (output, 1 each), addr (output, 5), bus_dout (output, 16, to the peripheral d_in) and bus_din (input, 16, from the peripheral d_out).

Function
REQ-017 The FSM SHALL have the states IDLE, WR_OP, WR_INIT1, WR_INIT0, POLL_REQ, POLL_CHK, RD_R_REQ, RD_R_CAP, RD_Q_REQ, RD_Q_CAP, DONE, each lasting one cycle.
REQ-018 Bus outputs SHALL be decoded from the state only (Moore), with the following values per state:
- WR_OP: cs=1, wr=1, addr=ADDR_OP, bus_dout=latched operand.
- WR_INIT1: cs=1, wr=1, addr=ADDR_INIT, bus_dout=16'h0001.
- WR_INIT0: cs=1, wr=1, addr=ADDR_INIT, bus_dout=0.
- POLL_REQ, RD_R_REQ, RD_Q_REQ: cs=1, rd=1, addr=ADDR_DONE / ADDR_R / ADDR_Q respectively.
- All other states: cs=rd=wr=0, addr=0, bus_dout=0.
REQ-019 The peripheral read data SHALL be treated as registered: bus_din is sampled in the *_CHK/*_CAP state immediately following the matching *_REQ state.
REQ-020 State transitions SHALL be:
- IDLE -> WR_OP when start=1.
- WR_OP -> WR_INIT1 -> WR_INIT0 -> POLL_REQ -> POLL_CHK.
- POLL_CHK -> RD_R_REQ if bus_din[0]=1, else -> POLL_REQ.
- RD_R_REQ -> RD_R_CAP (capture result_r) -> RD_Q_REQ -> RD_Q_CAP (capture result_q) -> DONE (valid=1) -> IDLE.
REQ-021 Minimum latency SHALL be valid high in the 10th cycle after the edge that samples start, when done=1 on the first poll.
REQ-022 start asserted while busy=1 SHALL be ignored, with no queuing; start asserted in DONE is ignored, and start in the following IDLE cycle is accepted.
REQ-023 operand changes after acceptance SHALL NOT affect bus_dout.
REQ-024 result_r and result_q SHALL hold their values until the next capture; full 16-bit values (e.g. 16'hFFFF) SHALL pass unmodified.
REQ-025 Upper bits bus_din[15:1] SHALL be ignored in POLL_CHK.

Reset
REQ-026 On a clock edge with rst=1, the state SHALL become IDLE and cs, rd, wr, addr, bus_dout, busy, valid, timeout, result_r, result_q and the latched operand SHALL all become 0, including mid-operation.
REQ-027 A start sampled at the same edge as rst=1 SHALL be dropped.

Configuration
REQ-028 With macro RAIZ_POLL_TIMEOUT_EN defined, the block SHALL count POLL_CHK visits with done=0, clearing the count on start acceptance.
REQ-029 With RAIZ_POLL_TIMEOUT_EN defined, when the POLL_MAX-th check sees done=0, the FSM SHALL go to IDLE, timeout SHALL pulse for 1 cycle, valid SHALL stay 0 and the results SHALL stay unchanged.
REQ-030 Without RAIZ_POLL_TIMEOUT_EN, the block SHALL poll indefinitely, the counter logic SHALL be absent, and timeout SHALL be tied to 0.

Verification
REQ-031 The bench SHALL cover: operand=16'd144, model sets done after 3 polls with R=0, Q=12 -> bus trace OP/INIT1/INIT0/3x(POLL_REQ,POLL_CHK)/R/Q; valid=1 with result_q=12 and result_r=0.
REQ-032 The bench SHALL cover: done=1 on the first poll -> valid exactly 10 cycles after start, and busy=0 in the next cycle.
REQ-033 The bench SHALL cover: start held high for 20 cycles -> exactly one write to ADDR_OP per completed command, the second command beginning in the IDLE cycle after DONE.
REQ-034 The bench SHALL cover: rst during POLL_REQ -> cs=rd=0 and busy=0 in the next cycle, results=0, and no valid.
REQ-035 The bench SHALL cover: macro on, POLL_MAX=4, done never set -> timeout pulse after the 4th POLL_CHK, busy=0, valid never asserted.
REQ-036 The bench SHALL cover: R=16'hFFFF, Q=16'hFFFF with bus_din upper bits garbage during polls -> results exactly 16'hFFFF, and polling ends only on bus_din[0].
